// File: rtl/ud_cnt_ctrl_if.sv
// ud_cnt_ctrl_if: sweep controller <-> environment bundle.
// Run control (START/ABORT/LO/HI/SWEEPS), counter link (Q/D/LD/UD/CE),
// and status (BUSY/DONE/ERR/SWEEP_CNT). slave = controller, master = env.
interface ud_cnt_ctrl_if #(
    parameter int W = 4
);
    logic         START;
    logic         ABORT;
    logic [W-1:0] LO;
    logic [W-1:0] HI;
    logic [3:0]   SWEEPS;
    logic [W-1:0] Q;
    logic [W-1:0] D;
    logic         LD;
    logic         UD;
    logic         CE;
    logic         BUSY;
    logic         DONE;
    logic         ERR;
    logic [3:0]   SWEEP_CNT;

    modport master (
        output START, ABORT, LO, HI, SWEEPS, Q,
        input  D, LD, UD, CE, BUSY, DONE, ERR, SWEEP_CNT
    );

    modport slave (
        input  START, ABORT, LO, HI, SWEEPS, Q,
        output D, LD, UD, CE, BUSY, DONE, ERR, SWEEP_CNT
    );
endinterface

// File: rtl/ud_cnt_ctrl.sv
// ud_cnt_ctrl: drives an up/down counter through LO->HI->LO triangle sweeps.
// Ports: CLK, RST_ (sync, active low), bus (ud_cnt_ctrl_if.slave).
module ud_cnt_ctrl #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST_,
    ud_cnt_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_FIN
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state, nxt;
    logic [W-1:0] lo_q, hi_q, exp_q;
    logic [W-1:0] nxt_lo, nxt_hi, nxt_exp;
    logic [3:0]   swp_q, cnt_q;
    logic [3:0]   nxt_swp, nxt_cnt;
    logic         nxt_err;
    logic         mism;
    logic         run_n;

    logic [W-1:0] d_q;
    logic         ld_q, ud_q, ce_q;
    logic         busy_q, done_q, err_q;

    always_comb begin
        nxt     = state;
        nxt_lo  = lo_q;
        nxt_hi  = hi_q;
        nxt_swp = swp_q;
        nxt_exp = exp_q;
        nxt_cnt = cnt_q;
        nxt_err = 1'b0;
        mism    = (bus.Q != exp_q);
        unique case (state)
            S_IDLE: begin
                if (bus.START) begin
                    if ((bus.LO < bus.HI) && (bus.SWEEPS != 4'd0)) begin
                        nxt     = S_LOAD;
                        nxt_lo  = bus.LO;
                        nxt_hi  = bus.HI;
                        nxt_swp = bus.SWEEPS;
                        nxt_cnt = 4'd0;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                nxt_exp = lo_q;
                nxt     = S_UP;
            end
            S_UP: begin
                if (mism) begin
                    nxt     = S_IDLE;
                    nxt_err = 1'b1;
                end else begin
                    nxt_exp = exp_q + ONE;
                    if (bus.Q == hi_q - ONE)
                        nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                if (mism) begin
                    nxt     = S_IDLE;
                    nxt_err = 1'b1;
                end else begin
                    nxt_exp = exp_q - ONE;
                    if (bus.Q == lo_q + ONE) begin
                        nxt_cnt = cnt_q + 4'd1;
                        nxt     = (nxt_cnt == swp_q) ? S_FIN : S_UP;
                    end
                end
            end
            S_FIN: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
        // Abort overrides a mismatch or a normal step; run state is frozen.
        if ((state != S_IDLE) && bus.ABORT) begin
            nxt     = S_IDLE;
            nxt_err = 1'b1;
            nxt_exp = exp_q;
            nxt_cnt = cnt_q;
        end
    end

    assign run_n = (nxt == S_LOAD) || (nxt == S_UP) || (nxt == S_DOWN);

    // Outputs are registered from the next state, so they line up
    // exactly with the state they decode.
    always_ff @(posedge CLK) begin
        if (!RST_) begin
            state  <= S_IDLE;
            lo_q   <= '0;
            hi_q   <= '0;
            swp_q  <= 4'd0;
            exp_q  <= '0;
            cnt_q  <= 4'd0;
            d_q    <= '0;
            ld_q   <= 1'b0;
            ud_q   <= 1'b0;
            ce_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= nxt;
            lo_q   <= nxt_lo;
            hi_q   <= nxt_hi;
            swp_q  <= nxt_swp;
            exp_q  <= nxt_exp;
            cnt_q  <= nxt_cnt;
            d_q    <= (nxt == S_LOAD) ? nxt_lo : '0;
            ld_q   <= (nxt == S_LOAD);
            ud_q   <= (nxt == S_UP);
            ce_q   <= run_n;
            busy_q <= run_n;
            done_q <= (nxt == S_FIN);
            err_q  <= nxt_err;
        end
    end

    // ABORT masks LD/CE in the same cycle so the counter holds the
    // value it showed when the abort was raised.
    assign bus.D         = d_q;
    assign bus.LD        = ld_q & ~bus.ABORT;
    assign bus.CE        = ce_q & ~bus.ABORT;
    assign bus.UD        = ud_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.SWEEP_CNT = cnt_q;
endmodule

// File: tb/tb_ud_cnt_ctrl.sv
// tb_ud_cnt_ctrl: vector table + per-cycle scoreboard for ud_cnt_ctrl,
// with a behavioural up/down counter closing the Q loop.
module tb_ud_cnt_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ud_cnt_ctrl_if #(.W(4)) bus ();

    ud_cnt_ctrl #(.W(4)) dut (
        .CLK (clk),
        .RST_(rst_n),
        .bus (bus.slave)
    );

    logic [3:0] cnt;
    logic       inj = 1'b0;
    logic [3:0] inj_val = 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (bus.LD)
            cnt <= bus.D;
        else if (bus.CE)
            cnt <= bus.UD ? cnt + 4'd1 : cnt - 4'd1;
    end

    assign bus.Q = inj ? inj_val : cnt;

    typedef struct packed {
        logic       ld;
        logic       ce;
        logic       ud;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] swc;
        logic [3:0] d;
        logic       qv;
        logic [3:0] q;
    } obs_t;

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] sw;
        int         exp_cycles;
        logic [3:0] exp_swc;
        int         exp_err;
    } vec_t;

    obs_t sbq[$];
    vec_t vt[8];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic ld, ce, ud, busy, done, err,
                                input logic [3:0] swc, d,
                                input logic qv, input logic [3:0] q);
        obs_t o;
        o = '{ld, ce, ud, busy, done, err, swc, d, qv, q};
        return o;
    endfunction

    function automatic obs_t sample(input logic qv);
        return mk(bus.LD, bus.CE, bus.UD, bus.BUSY, bus.DONE, bus.ERR,
                  bus.SWEEP_CNT, bus.D, qv, qv ? bus.Q : 4'd0);
    endfunction

    task automatic push_run(input logic [3:0] lo, hi, sw);
        int span = int'(hi) - int'(lo);
        sbq.push_back(mk(1, 1, 0, 1, 0, 0, 4'd0, lo, 0, 4'd0));
        for (int k = 0; k < int'(sw); k++) begin
            for (int i = 0; i < span; i++)
                sbq.push_back(mk(0, 1, 1, 1, 0, 0, 4'(k), 4'd0, 1,
                                 lo + 4'(i)));
            for (int i = 0; i < span; i++)
                sbq.push_back(mk(0, 1, 0, 1, 0, 0, 4'(k), 4'd0, 1,
                                 hi - 4'(i)));
        end
        sbq.push_back(mk(0, 0, 0, 0, 1, 0, sw, 4'd0, 1, lo));
        sbq.push_back(mk(0, 0, 0, 0, 0, 0, sw, 4'd0, 1, lo));
    endtask

    task automatic start_run(input logic [3:0] lo, hi, sw);
        @(negedge clk);
        bus.LO = lo;
        bus.HI = hi;
        bus.SWEEPS = sw;
        bus.START = 1'b1;
        @(posedge clk);
        #1 bus.START = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        obs_t e, a;
        int   idx = 0;
        int   done_at = 0;
        int   errs = 0;
        logic ok = (v.lo < v.hi) && (v.sw != 4'd0);
        if (ok) begin
            push_run(v.lo, v.hi, v.sw);
        end else begin
            sbq.push_back(mk(0, 0, 0, 0, 0, 1, v.exp_swc, 4'd0, 0, 4'd0));
            sbq.push_back(mk(0, 0, 0, 0, 0, 0, v.exp_swc, 4'd0, 0, 4'd0));
        end
        start_run(v.lo, v.hi, v.sw);
        while (sbq.size() > 0) begin
            @(negedge clk);
            e = sbq.pop_front();
            a = sample(e.qv);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL vec%0d cyc%0d act=%h exp=%h", id, idx, a, e);
            end
            if (a.done && done_at == 0)
                done_at = idx + 2;
            if (a.err)
                errs++;
            idx++;
        end
        chk($sformatf("vec%0d_len", id), done_at, v.exp_cycles);
        chk($sformatf("vec%0d_errs", id), errs, v.exp_err);
        chk($sformatf("vec%0d_swc", id), bus.SWEEP_CNT, v.exp_swc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic found;
        vec_t rv;
        vt[0] = '{4'd2,  4'd5,  4'd1,  9,  4'd1,  0};
        vt[1] = '{4'd0,  4'd1,  4'd3,  9,  4'd3,  0};
        vt[2] = '{4'd5,  4'd5,  4'd1,  0,  4'd3,  1};
        vt[3] = '{4'd3,  4'd7,  4'd0,  0,  4'd3,  1};
        vt[4] = '{4'd9,  4'd4,  4'd2,  0,  4'd3,  1};
        vt[5] = '{4'd14, 4'd15, 4'd1,  5,  4'd1,  0};
        vt[6] = '{4'd0,  4'd15, 4'd1,  33, 4'd1,  0};
        vt[7] = '{4'd4,  4'd6,  4'd15, 63, 4'd15, 0};

        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.LO = 4'd0;
        bus.HI = 4'd0;
        bus.SWEEPS = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_outs",
            {bus.D, bus.LD, bus.UD, bus.CE, bus.BUSY, bus.DONE,
             bus.ERR, bus.SWEEP_CNT}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec(vt[i], i);

        // abort while descending through Q=4
        start_run(4'd1, 4'd9, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.BUSY && !bus.UD && bus.Q == 4'd4)
                found = 1'b1;
        end
        chk("abort_seen", found, 1);
        bus.ABORT = 1'b1;
        #1;
        chk("abort_ce_mask", bus.CE, 0);
        @(negedge clk);
        bus.ABORT = 1'b0;
        chk("abort_err", bus.ERR, 1);
        chk("abort_idle", {bus.BUSY, bus.CE, bus.LD, bus.DONE}, 0);
        chk("abort_q", bus.Q, 4);
        @(negedge clk);
        chk("abort_err_pulse", bus.ERR, 0);
        chk("abort_q_hold", bus.Q, 4);

        // corrupted Q during the second sweep's ascent
        start_run(4'd1, 4'd9, 4'd2);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus.BUSY && bus.UD && bus.Q == 4'd3 && bus.SWEEP_CNT == 4'd1)
                found = 1'b1;
        end
        chk("fault_seen", found, 1);
        inj_val = 4'd7;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("fault_err", bus.ERR, 1);
        chk("fault_idle", {bus.BUSY, bus.CE, bus.DONE}, 0);
        chk("fault_swc", bus.SWEEP_CNT, 1);
        @(negedge clk);
        chk("fault_err_pulse", bus.ERR, 0);

        // reset in the middle of an ascent
        start_run(4'd2, 4'd8, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.BUSY && bus.UD && bus.Q == 4'd4)
                found = 1'b1;
        end
        chk("rst_seen", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs",
            {bus.D, bus.LD, bus.UD, bus.CE, bus.BUSY, bus.DONE,
             bus.ERR, bus.SWEEP_CNT}, 0);
        rst_n = 1'b1;
        rv = '{4'd10, 4'd12, 4'd2, 11, 4'd2, 0};
        run_vec(rv, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
